// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter.
// Mode encodings used by the top and by each shift stage.
package pipelined_barrel_shifter_pkg;

  typedef enum logic [1:0] {
    MODE_ROR = 2'b00,
    MODE_ROL = 2'b01,
    MODE_LSR = 2'b10,
    MODE_ASR = 2'b11
  } mode_e;

endpackage

// File: rtl/pipelined_barrel_shifter_stage.sv
// One fixed-distance move of the barrel shifter.
// Purely combinational; the parent registers the result.
module shifter_stage
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  mode_e            mode_i,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    unique case (mode_i)
      MODE_ROR: data_o = {data_i[DIST-1:0],
                          data_i[WIDTH-1:DIST]};
      MODE_ROL: data_o = {data_i[WIDTH-DIST-1:0],
                          data_i[WIDTH-1:WIDTH-DIST]};
      MODE_LSR: data_o = data_i >> DIST;
      // sign is preserved by every earlier ASR stage
      MODE_ASR: data_o = $signed(data_i) >>> DIST;
    endcase
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one log2 stage per register,
// global stall driven by the output handshake.
module pipelined_barrel_shifter
  import pipelined_barrel_shifter_pkg::*;
#(
  parameter int  WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic [SHW-1:0]   i_shift,
  input  logic [1:0]       i_mode,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_mode,
  output logic             o_valid,
  input  logic             o_ready
);

  logic [WIDTH-1:0] data_q [SHW];
  logic [WIDTH-1:0] data_d [SHW];
  logic [1:0]       mode_q [SHW];
  logic [1:0]       mode_d [SHW];
  logic [SHW-1:0]   rem_q  [SHW];
  logic [SHW-1:0]   rem_d  [SHW];
  logic [SHW-1:0]   valid_q;
  logic [SHW-1:0]   valid_d;
  logic             en;

  assign en      = o_ready | ~o_valid;
  assign i_ready = en & ~rst;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] mv_data;
    logic [1:0]       in_mode;
    logic [SHW-1:0]   in_rem;
    logic             in_valid;

    if (k == 0) begin : g_head
      assign in_data  = i_data;
      assign in_mode  = i_mode;
      assign in_rem   = i_shift;
      assign in_valid = i_valid;
    end else begin : g_tail
      assign in_data  = data_q[k-1];
      assign in_mode  = mode_q[k-1];
      assign in_rem   = rem_q[k-1];
      assign in_valid = valid_q[k-1];
    end

    shifter_stage #(
      .WIDTH (WIDTH),
      .DIST  (2 ** k)
    ) u_stage (
      .data_i (in_data),
      .mode_i (mode_e'(in_mode)),
      .data_o (mv_data)
    );

    // remaining shift bits travel down, LSB first
    assign data_d[k]  = in_rem[0] ? mv_data : in_data;
    assign mode_d[k]  = in_mode;
    assign rem_d[k]   = in_rem >> 1;
    assign valid_d[k] = in_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < SHW; k++) begin
        data_q[k] <= '0;
        mode_q[k] <= '0;
        rem_q[k]  <= '0;
      end
    end else if (en) begin
      valid_q <= valid_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
    end
  end

  assign o_data  = data_q[SHW-1];
  assign o_mode  = mode_q[SHW-1];
  assign o_valid = valid_q[SHW-1];

endmodule
